// File: rtl/pipe_alu_param.sv
// pipe_alu_param: four-stage register-to-register ALU pipeline.
// Stages: operand fetch (l12), execute (l23), writeback (l34), store.
// Operands are forwarded at fetch from the execute-stage ALU output and
// from the writeback-stage result, so dependent instructions never stall.
module pipe_alu_param #(
  parameter int DW = 16,
  parameter int RN = 16,
  parameter int MD = 256,
  localparam int RW = $clog2(RN),
  localparam int AW = $clog2(MD)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          stall,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] Zout,
  output logic          Zvalid,
  output logic          Zflag,
  output logic          Cflag,
  input  logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_rdata
);

  // per-stage valid shift register: [1]=execute, [2]=writeback, [3]=store
  logic [3:1]    r_vld;

  // fetch -> execute
  logic [DW-1:0] r_a12, r_b12;
  logic [3:0]    r_f12;
  logic [RW-1:0] r_rd12;
  logic [AW-1:0] r_ad12;

  // execute -> writeback
  logic [DW-1:0] r_z23;
  logic          r_c23;
  logic [RW-1:0] r_rd23;
  logic [AW-1:0] r_ad23;

  // writeback -> store
  logic [DW-1:0] r_z34;
  logic [AW-1:0] r_ad34;

  logic          r_zf, r_cf;
  logic [DW-1:0] r_reg [RN];
  logic [DW-1:0] r_mem [MD];
  logic [DW-1:0] r_rdata;

  logic [DW-1:0] w_alu;
  logic          w_cy;
  logic          w_legal;
  logic [DW-1:0] w_opa, w_opb;

  assign w_legal = (r_f12 != 4'd15);

  // ALU on the execute-stage operands; opcode 15 yields 0 and is dropped
  always_comb begin
    w_alu = '0;
    w_cy  = 1'b0;
    case (r_f12)
      4'd0:  {w_cy, w_alu} = {1'b0, r_a12} + {1'b0, r_b12};
      4'd1:  {w_cy, w_alu} = {1'b0, r_a12} - {1'b0, r_b12};
      4'd2:  w_alu = r_a12 * r_b12;
      4'd3:  w_alu = r_a12;
      4'd4:  w_alu = r_b12;
      4'd5:  w_alu = r_a12 & r_b12;
      4'd6:  w_alu = r_a12 | r_b12;
      4'd7:  w_alu = r_a12 ^ r_b12;
      4'd8:  w_alu = ~r_a12;
      4'd9:  w_alu = ~r_b12;
      4'd10: w_alu = r_a12 >> 1;
      4'd11: w_alu = r_a12 << 1;
      4'd12: w_alu = {r_a12[0], r_a12[DW-1:1]};
      4'd13: w_alu = {r_a12[DW-2:0], r_a12[DW-1]};
      4'd14: w_alu = {r_a12[DW-1], r_a12[DW-1:1]};
      default: w_alu = '0;
    endcase
  end

  // operand select: newest producer wins (execute, then writeback, then bank)
  always_comb begin
    w_opa = r_reg[rs1];
    w_opb = r_reg[rs2];
    if (r_vld[1] && w_legal && r_rd12 == rs1) w_opa = w_alu;
    else if (r_vld[2] && r_rd23 == rs1)       w_opa = r_z23;
    if (r_vld[1] && w_legal && r_rd12 == rs2) w_opb = w_alu;
    else if (r_vld[2] && r_rd23 == rs2)       w_opb = r_z23;
  end

  // pipeline registers and flags; stall freezes everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld  <= '0;
      r_a12  <= '0;
      r_b12  <= '0;
      r_f12  <= '0;
      r_rd12 <= '0;
      r_ad12 <= '0;
      r_z23  <= '0;
      r_c23  <= 1'b0;
      r_rd23 <= '0;
      r_ad23 <= '0;
      r_z34  <= '0;
      r_ad34 <= '0;
      r_zf   <= 1'b0;
      r_cf   <= 1'b0;
    end else if (!stall) begin
      r_vld[1] <= in_valid;
      r_a12    <= w_opa;
      r_b12    <= w_opb;
      r_f12    <= func;
      r_rd12   <= rd;
      r_ad12   <= addr;
      r_vld[2] <= r_vld[1] & w_legal;
      r_z23    <= w_alu;
      r_c23    <= w_cy;
      r_rd23   <= r_rd12;
      r_ad23   <= r_ad12;
      r_vld[3] <= r_vld[2];
      r_z34    <= r_z23;
      r_ad34   <= r_ad23;
      if (r_vld[2]) begin
        r_zf <= (r_z23 == '0);
        r_cf <= r_c23;
      end
    end
  end

  // register bank written from the writeback stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RN; i++) r_reg[i] <= '0;
    end else if (!stall && r_vld[2]) begin
      r_reg[r_rd23] <= r_z23;
    end
  end

  // data memory store; contents survive reset, in-flight stores are dropped
  always_ff @(posedge CLK) begin
    if (!RST && !stall && r_vld[3]) r_mem[r_ad34] <= r_z34;
  end

  // registered read-back port, keeps running through stalls
  always_ff @(posedge CLK) begin
    if (RST) r_rdata <= '0;
    else     r_rdata <= r_mem[mem_raddr];
  end

  assign in_ready  = ~stall;
  assign Zout      = r_z34;
  assign Zvalid    = r_vld[3];
  assign Zflag     = r_zf;
  assign Cflag     = r_cf;
  assign mem_rdata = r_rdata;

endmodule
